dwt_frame_sequencer: RTL
========================

Name: dwt_frame_sequencer

Overview:
- Frame-level controller placed in front of the 2-D 9/7 DWT pipeline (column DWT, border expander, transpose, row DWT).
- Takes an unframed stream of {odd, even} sample pairs plus a software-programmed geometry, and generates the sof/eol framing the core requires.
- Admits exactly one frame into the core at a time.
- Snoops the core's output handshake to detect frame completion and framing errors, then reports done or error to the host.

Parameters:
- DataWidth, 16, width of one sample; the stream carries 2*DataWidth bits.
- MaximumSideSize, 512, largest frame side in samples; must match the DWT core.
- SizeWidth, $clog2(MaximumSideSize+1), width of the geometry fields and counters (derived; not to be overridden).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  start request; sampled only in IDLE
- cfg_width_i  in  SizeWidth  sample pairs per input line
- cfg_height_i  in  SizeWidth  input lines per frame
- cfg_out_lines_i  in  SizeWidth  expected output eol count per frame
- busy_o  out  1  high in FEED or DRAIN
- done_o  out  1  one-cycle pulse when the output frame completes
- err_o  out  1  sticky error; cleared by the next accepted start_i
- s_ready_o  out  1  raw input ready
- s_valid_i  in  1  raw input valid
- s_data_i  in  2*DataWidth  raw input pair
- m_ready_i  in  1  core input ready
- m_valid_o  out  1  core input valid
- m_sof_o  out  1  first beat of frame
- m_eol_o  out  1  last beat of line
- m_data_o  out  2*DataWidth  pair to core
- mon_valid_i  in  1  core output valid (snooped)
- mon_ready_i  in  1  core output ready (snooped)
- mon_sof_i  in  1  core output sof (snooped)
- mon_eol_i  in  1  core output eol (snooped)

Behaviour:
- Reset values:
  - State IDLE; all counters 0.
  - busy_o, done_o and err_o are 0.
  - s_ready_o and m_valid_o are 0.
  - Any frame in flight is abandoned; no attempt is made to flush the core.
- States:
  - IDLE -> FEED: on start_i with a legal geometry. The geometry is latched, err_o is cleared, and the column, row and output-line counters are zeroed.
  - Illegal geometry: width 0, height 0, out_lines 0, width > MaximumSideSize/2, or height > MaximumSideSize. On start_i with illegal geometry, err_o is set and the state stays IDLE.
  - FEED -> DRAIN: on the handshake of the last beat (col == width-1 and row == height-1).
  - DRAIN -> IDLE: when the output-line count reaches out_lines. done_o pulses in that same cycle.
- FEED datapath:
  - Combinational passthrough with zero latency: m_valid_o = s_valid_i, s_ready_o = m_ready_i, m_data_o = s_data_i.
  - m_sof_o = (col == 0 && row == 0).
  - m_eol_o = (col == width-1).
  - The counters advance only on an m_valid_o && m_ready_i handshake. col wraps to 0 and row increments on eol.
- IDLE and DRAIN: s_ready_o = 0 and m_valid_o = 0. m_data_o holds s_data_i; its value is don't-care.
- Output monitor (active in FEED and DRAIN):
  - The output-line count increments on mon_valid_i && mon_ready_i && mon_eol_i.
  - Output eols arriving during FEED are counted, because the core overlaps input and output.
- Error detection (sets err_o; the sequence continues):
  - A monitored sof handshake when out_count != 0 or the monitor beat count != 0.
  - A monitored beat of any kind while in IDLE.
- Simultaneous events:
  - An output eol that completes out_lines in the same cycle as the final FEED input beat goes FEED -> IDLE directly, and done_o pulses.
  - start_i asserted in the same cycle as a done_o pulse is ignored; start_i is accepted only in IDLE.

Optional Feature:
- Macro: DWT_FRAME_SEQUENCER_TIMEOUT_EN.
- With the macro defined:
  - Adds parameter TimeoutCycles (default 1<<20) and a watchdog counter.
  - The counter resets on every monitored handshake and on entry to DRAIN, and runs in DRAIN.
  - On reaching TimeoutCycles, err_o is set, done_o is not pulsed, and the state returns to IDLE.
- Without the macro: DRAIN waits indefinitely and no counter logic is present.

Decomposition:
- Package dwt_frame_sequencer_pkg holds:
  - the state enum (IDLE, FEED, DRAIN);
  - the function computing SizeWidth from MaximumSideSize;
  - a geometry struct {width, height, out_lines}.
- One sub-module, dwt_seq_line_counter: column/row counter with enable, wrap and last-beat flags, driven by the handshake.

Test Plan:
- Width 4, height 2, out_lines 8, continuous valid:
  - sof on beat 0 only; eol on beats 3 and 7.
  - busy_o is high for the whole frame.
  - Feeding 8 output eols pulses done_o once and returns to IDLE.
- Same geometry with random m_ready_i and s_valid_i stalls:
  - Framing positions are identical to the unstalled case.
  - No beat is duplicated or dropped (data compared by scoreboard).
- start_i with width 0, then with width 257 (MaximumSideSize 512):
  - err_o rises, state stays IDLE, s_ready_o stays 0.
  - A following legal start_i clears err_o.
- Inject a spurious mon_sof_i on the third output line: err_o rises and stays high, and done_o still pulses at 8 eols.
- Assert rst_i during FEED at row 1, col 2:
  - Next cycle all outputs are 0 and the state is IDLE.
  - A new start_i frame begins with sof at col 0, row 0.
- Macro defined, TimeoutCycles 100, no output eols after FEED: after 100 DRAIN cycles err_o rises, state is IDLE, and done_o never pulses.

Source files
------------

// File: rtl/dwt_frame_sequencer_pkg.sv
// Shared state encoding, geometry record and sizing helper for dwt_frame_sequencer.
package dwt_frame_sequencer_pkg;

  localparam int GeomW = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FEED  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef struct packed {
    logic [GeomW-1:0] width;
    logic [GeomW-1:0] height;
    logic [GeomW-1:0] out_lines;
  } geom_t;

  function automatic int calc_size_width(input int max_side);
    return $clog2(max_side + 1);
  endfunction

endpackage

// File: rtl/dwt_seq_line_counter.sv
// Column/row position of the input stream; advances on each accepted beat.
module dwt_seq_line_counter
  import dwt_frame_sequencer_pkg::*;
#(
  parameter int CountWidth = GeomW
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  en_i,
  input  logic [CountWidth-1:0] width_i,
  input  logic [CountWidth-1:0] height_i,
  output logic                  first_o,
  output logic                  eol_o,
  output logic                  last_o
);

  logic [CountWidth-1:0] col_q, col_d;
  logic [CountWidth-1:0] row_q, row_d;

  assign first_o = (col_q == '0) && (row_q == '0);
  assign eol_o   = (col_q == width_i - CountWidth'(1));
  assign last_o  = eol_o && (row_q == height_i - CountWidth'(1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (en_i) begin
      if (eol_o) begin
        col_d = '0;
        row_d = row_q + CountWidth'(1);
      end else begin
        col_d = col_q + CountWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/dwt_frame_sequencer.sv
// Frames a raw pair stream for the 2-D DWT core, one frame at a time, and snoops the core output.
// Optional watchdog in DRAIN: define DWT_FRAME_SEQUENCER_TIMEOUT_EN.
module dwt_frame_sequencer
  import dwt_frame_sequencer_pkg::*;
#(
  parameter int DataWidth       = 16,
  parameter int MaximumSideSize = 512,
`ifdef DWT_FRAME_SEQUENCER_TIMEOUT_EN
  parameter int TimeoutCycles   = 1 << 20,
`endif
  localparam int SizeWidth      = calc_size_width(MaximumSideSize)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [SizeWidth-1:0]   cfg_width_i,
  input  logic [SizeWidth-1:0]   cfg_height_i,
  input  logic [SizeWidth-1:0]   cfg_out_lines_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic                   s_ready_o,
  input  logic                   s_valid_i,
  input  logic [2*DataWidth-1:0] s_data_i,
  input  logic                   m_ready_i,
  output logic                   m_valid_o,
  output logic                   m_sof_o,
  output logic                   m_eol_o,
  output logic [2*DataWidth-1:0] m_data_o,
  input  logic                   mon_valid_i,
  input  logic                   mon_ready_i,
  input  logic                   mon_sof_i,
  input  logic                   mon_eol_i,
  output logic [1:0]             dbg_state_o
);

  // Both streams use valid/ready: a beat transfers in any cycle where valid && ready.
  logic [1:0]       state_q, state_d;
  geom_t            geom_q, geom_d;
  logic [GeomW-1:0] out_count_q, out_count_d;
  logic             mid_line_q, mid_line_d;
  logic             err_q, err_d;
  logic             done;
  logic             feed, in_hs, mon_hs, mon_active, cfg_legal, start_ok, out_done;
  logic             cnt_first, cnt_eol, cnt_last;

  assign feed       = (state_q == ST_FEED);
  assign in_hs      = feed && s_valid_i && m_ready_i;
  assign mon_hs     = mon_valid_i && mon_ready_i;
  assign mon_active = (state_q != ST_IDLE);
  assign cfg_legal  = (cfg_width_i != '0) && (cfg_height_i != '0) && (cfg_out_lines_i != '0)
                   && (cfg_width_i <= SizeWidth'(MaximumSideSize / 2))
                   && (cfg_height_i <= SizeWidth'(MaximumSideSize));
  assign start_ok   = (state_q == ST_IDLE) && start_i && cfg_legal;
  assign out_done   = (out_count_d >= geom_q.out_lines);

  dwt_seq_line_counter #(.CountWidth(GeomW)) u_line_counter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (start_ok),
    .en_i     (in_hs),
    .width_i  (geom_q.width),
    .height_i (geom_q.height),
    .first_o  (cnt_first),
    .eol_o    (cnt_eol),
    .last_o   (cnt_last)
  );

  // Output eols are counted in FEED as well, since the core overlaps input and output.
  always_comb begin
    out_count_d = out_count_q;
    mid_line_d  = mid_line_q;
    if (start_ok) begin
      out_count_d = '0;
      mid_line_d  = 1'b0;
    end else if (mon_active && mon_hs) begin
      mid_line_d = !mon_eol_i;
      if (mon_eol_i && (out_count_q != '1)) out_count_d = out_count_q + GeomW'(1);
    end
  end

`ifdef DWT_FRAME_SEQUENCER_TIMEOUT_EN
  localparam int WdW = $clog2(TimeoutCycles + 1);
  logic [WdW-1:0] wd_q, wd_d;
  logic           timeout;

  assign timeout = (state_q == ST_DRAIN) && (wd_q == WdW'(TimeoutCycles - 1));

  always_comb begin
    wd_d = wd_q + WdW'(1);
    if (mon_hs || (state_q != ST_DRAIN)) wd_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) wd_q <= '0;
    else       wd_q <= wd_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    geom_d  = geom_q;
    err_d   = err_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (cfg_legal) begin
            geom_d.width     = GeomW'(cfg_width_i);
            geom_d.height    = GeomW'(cfg_height_i);
            geom_d.out_lines = GeomW'(cfg_out_lines_i);
            err_d            = 1'b0;
            state_d          = ST_FEED;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_FEED: begin
        if (in_hs && cnt_last) begin
          if (out_done) begin
            state_d = ST_IDLE;
            done    = 1'b1;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (out_done) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end
`ifdef DWT_FRAME_SEQUENCER_TIMEOUT_EN
        else if (timeout) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    // Framing errors are flagged but never stop the sequence.
    if (mon_hs && !mon_active) err_d = 1'b1;
    if (mon_hs && mon_active && mon_sof_i && ((out_count_q != '0) || mid_line_q)) err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      geom_q      <= '0;
      out_count_q <= '0;
      mid_line_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      geom_q      <= geom_d;
      out_count_q <= out_count_d;
      mid_line_q  <= mid_line_d;
      err_q       <= err_d;
    end
  end

  assign busy_o      = mon_active;
  assign done_o      = done;
  assign err_o       = err_q;
  assign s_ready_o   = feed && m_ready_i;
  assign m_valid_o   = feed && s_valid_i;
  assign m_data_o    = s_data_i;
  assign m_sof_o     = feed && cnt_first;
  assign m_eol_o     = feed && cnt_eol;
  assign dbg_state_o = state_q;

endmodule
